// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and types for the I2S DAC serializer
//
// Purpose : frame geometry, LR-clock slot polarity and the stereo sample pair
//           type used by the DAC serializer and its sample FIFO.
// Ports   : none (package).

package audio_pkg;

   localparam int AUDIO_DATA_WIDTH = 32;   // channel width carried by stereo_pair_t
   localparam int SLOT_BITS        = 32;   // BCLK periods per channel slot
   localparam int FRAME_BITS       = 64;   // BCLK periods per stereo frame

   // AUD_DACLRCK level for each channel slot
   localparam logic LEFT  = 1'b0;
   localparam logic RIGHT = 1'b1;

   typedef struct packed {
      logic [AUDIO_DATA_WIDTH-1:0] left;
      logic [AUDIO_DATA_WIDTH-1:0] right;
   } stereo_pair_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous FIFO with push, pop, clear and level
//
// Purpose : buffers stereo pairs between the game logic and the serializer.
//           Full/empty come from the occupancy count, so the pointers are
//           free to wrap naturally.
// Ports   : clk_i, rst_ni   - clock, asynchronous active-low reset
//           push_i, wdata_i - write request and data (ignored when full)
//           pop_i, rdata_o  - read request (ignored when empty), head data
//           clear_i         - flush; wins over push and pop
//           full_o, empty_o, level_o - occupancy status

module audio_sample_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   input  logic             clear_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == LVL_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign rdata_o = mem[rd_ptr_q];

   // Full is judged on the registered count, so a push while full is lost
   // even when a pop frees a slot in the same cycle.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: a zero count makes old contents unreachable.
   always_ff @(posedge clk_i) begin
      if (push_ok && !clear_i) mem[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - master-mode I2S transmitter for the WM8731 DAC path
//
// Purpose : buffers stereo pairs from game logic, generates AUD_BCLK and
//           AUD_DACLRCK, and shifts each channel out MSB-first (one BCLK
//           delay bit, OUT_BITS data bits, zero padding) on AUD_DACDAT.
// Ports   : CLOCK_50, resetn                 - clock, asynchronous active-low reset
//           left/right_channel_audio_out     - stereo sample pair to queue
//           write_audio_out                  - push request
//           clear_audio_out_memory           - FIFO flush
//           audio_out_allowed, fifo_level    - FIFO status
//           underflow                        - frame started with FIFO empty
//           AUD_BCLK, AUD_DACLRCK, AUD_DACDAT - codec pins

module audio_dac_serializer
   import audio_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int OUT_BITS   = 24,
   parameter  int BCLK_DIV   = 8,
   parameter  int FIFO_DEPTH = 8,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  CLOCK_50,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
   input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
   input  logic                  write_audio_out,
   input  logic                  clear_audio_out_memory,
   output logic                  audio_out_allowed,
   output logic [LVL_W-1:0]      fifo_level,
   output logic                  underflow,
   output logic                  AUD_BCLK,
   output logic                  AUD_DACLRCK,
   output logic                  AUD_DACDAT
);

   localparam int              DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);
   localparam int              BIT_W   = $clog2(FRAME_BITS);
   localparam int              K_W     = $clog2(SLOT_BITS);
   localparam logic [K_W:0]    OUT_LIM = (K_W + 1)'(OUT_BITS);

   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic                  bclk_q, bclk_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  dacdat_q, dacdat_d;
   logic                  underflow_q, underflow_d;
   logic [DATA_WIDTH-1:0] left_sr_q, left_sr_d;
   logic [DATA_WIDTH-1:0] right_sr_q, right_sr_d;

   logic [2*DATA_WIDTH-1:0] fifo_rdata;
   logic                    fifo_full, fifo_empty, fifo_pop;
   logic                    div_wrap, bclk_fall, frame_start;
   logic [BIT_W-1:0]        bit_cnt_nxt;
   logic [K_W-1:0]          k;
   logic                    slot;

   audio_sample_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (CLOCK_50),
      .rst_ni  (resetn),
      .push_i  (write_audio_out),
      .wdata_i ({left_channel_audio_out, right_channel_audio_out}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .clear_i (clear_audio_out_memory),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign div_wrap    = (div_cnt_q == DIV_MAX);
   assign bclk_fall   = div_wrap && bclk_q;
   assign frame_start = bclk_fall && (bit_cnt_q == BIT_W'(FRAME_BITS - 1));
   assign fifo_pop    = frame_start && !fifo_empty && !clear_audio_out_memory;

   // Data for a bit period is chosen from the bit index it is about to enter.
   assign bit_cnt_nxt = bit_cnt_q + 1'b1;
   assign k           = bit_cnt_nxt[K_W-1:0];
   assign slot        = bit_cnt_nxt[K_W];

   always_comb begin
      div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
      bclk_d      = bclk_q ^ div_wrap;
      bit_cnt_d   = bit_cnt_q;
      dacdat_d    = dacdat_q;
      left_sr_d   = left_sr_q;
      right_sr_d  = right_sr_q;
      underflow_d = frame_start && fifo_empty;

      if (bclk_fall) begin
         bit_cnt_d = bit_cnt_nxt;
         dacdat_d  = 1'b0;
         if (frame_start) begin
            // Delay bit of the left slot; load the new pair (or silence).
            if (fifo_pop) begin
               left_sr_d  = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
               right_sr_d = fifo_rdata[DATA_WIDTH-1:0];
            end else begin
               left_sr_d  = '0;
               right_sr_d = '0;
            end
         end else if ((k != '0) && ({1'b0, k} <= OUT_LIM)) begin
            if (slot == RIGHT) begin
               dacdat_d   = right_sr_q[DATA_WIDTH-1];
               right_sr_d = {right_sr_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
               dacdat_d  = left_sr_q[DATA_WIDTH-1];
               left_sr_d = {left_sr_q[DATA_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         div_cnt_q   <= '0;
         bclk_q      <= 1'b0;
         bit_cnt_q   <= '0;
         dacdat_q    <= 1'b0;
         underflow_q <= 1'b0;
         left_sr_q   <= '0;
         right_sr_q  <= '0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         bclk_q      <= bclk_d;
         bit_cnt_q   <= bit_cnt_d;
         dacdat_q    <= dacdat_d;
         underflow_q <= underflow_d;
         left_sr_q   <= left_sr_d;
         right_sr_q  <= right_sr_d;
      end
   end

   assign audio_out_allowed = !fifo_full;
   assign underflow         = underflow_q;
   assign AUD_BCLK          = bclk_q;
   assign AUD_DACLRCK       = bit_cnt_q[BIT_W-1];
   assign AUD_DACDAT        = dacdat_q;

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Master-mode I2S transmitter for the WM8731 codec DAC path on the DE1-SoC.
- Accepts stereo sample pairs from game logic through the existing write_audio_out / audio_out_allowed handshake and buffers them in a small FIFO.
- Generates AUD_BCLK and AUD_DACLRCK, and shifts samples out MSB-first on AUD_DACDAT.
- Sits between the hit/miss tone generator and the codec pins, in place of the DAC half of the audio controller.

Parameters:
- DATA_WIDTH, 32, width of each channel sample presented at the input.
- OUT_BITS, 24, number of MSBs transmitted per channel. Must satisfy OUT_BITS <= 31.
- BCLK_DIV, 8, CLOCK_50 cycles per BCLK half-period.
- FIFO_DEPTH, 8, number of stereo pairs buffered. Must be a power of 2.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous reset, active low.
- left_channel_audio_out  in  DATA_WIDTH  left sample, two's complement.
- right_channel_audio_out  in  DATA_WIDTH  right sample, two's complement.
- write_audio_out  in  1  push request for one stereo pair.
- clear_audio_out_memory  in  1  synchronous FIFO flush.
- audio_out_allowed  out  1  FIFO not full.
- fifo_level  out  log2(FIFO_DEPTH)+1  number of pairs currently stored.
- underflow  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- AUD_BCLK  out  1  bit clock.
- AUD_DACLRCK  out  1  LR clock; 0 = left slot, 1 = right slot.
- AUD_DACDAT  out  1  serial data.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is asynchronous and active-low on resetn.
- Reset values: AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, underflow=0, fifo_level=0, audio_out_allowed=1. Divider counter, bit counter and shift registers are all 0.
- Reset mid-frame: takes effect immediately. FIFO contents are discarded and the frame is abandoned.
- BCLK generation:
  - div_cnt counts 0..BCLK_DIV-1.
  - AUD_BCLK toggles on the cycle div_cnt==BCLK_DIV-1.
  - With default parameters, BCLK falling edges occur at cycles 16n after reset release.
- Bit counter:
  - bit_cnt is 6 bits and increments mod 64 on each BCLK falling edge.
  - AUD_DACLRCK = bit_cnt[5].
  - One frame = 64 BCLK periods = 1024 CLOCK_50 cycles (default).
- Frame start (bit_cnt wraps 63->0):
  - If the FIFO is non-empty, pop one pair into the left and right shift registers.
  - If it is empty, load zeros and pulse underflow for exactly one CLOCK_50 cycle.
  - The first frame after reset is always silent. The first pop occurs at the first wrap, cycle 1024 by default.
- Data timing:
  - AUD_DACDAT updates only on BCLK falling edges.
  - Let k = bit_cnt[4:0]. k=0 is the I2S delay bit and carries 0.
  - For 1<=k<=OUT_BITS, AUD_DACDAT = sample[DATA_WIDTH-k] of the current slot's channel.
  - For k>OUT_BITS, AUD_DACDAT = 0.
  - The lower DATA_WIDTH-OUT_BITS bits are truncated, not rounded.
- Write handshake:
  - audio_out_allowed = (fifo_level != FIFO_DEPTH), derived from the registered count.
  - A push happens when write_audio_out && audio_out_allowed.
  - A write while full is silently dropped, even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): fifo_level is unchanged and data order is preserved.
- Clear:
  - clear_audio_out_memory empties the FIFO on the next edge (fifo_level=0).
  - A write in the same cycle is dropped.
  - The frame currently shifting completes unaffected.
  - Clear has priority over both pop and push.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are determined from the count, not from pointer equality.

Decomposition:
- Package audio_pkg holds:
  - SLOT_BITS=32 and FRAME_BITS=64.
  - The LRCK polarity constants LEFT=0 and RIGHT=1.
  - A stereo-pair struct {left, right} of DATA_WIDTH each.
- One sub-module, audio_sample_fifo: synchronous FIFO with push, pop, clear and level.
- The top of this block holds the divider, bit counter and shift logic.

Test Plan:
- Reset: hold resetn=0 then release with no writes -> BCLK period 16 cycles, LRCK toggles every 512 cycles, DACDAT=0 for the whole frame, underflow pulses once at cycle 1024, allowed=1, level=0.
- Single pair: write L=32'hA5A5A5FF, R=32'h5A5A5A00 at cycle 10 -> level=1. At cycle 1024 the pair pops (level=0). Captured left bits 1..24 = 0xA5A5A5, bits 0 and 25..31 = 0; right slot = 0x5A5A5A.
- Full: 9 back-to-back writes -> allowed drops after the 8th, 9th write dropped, level=8. After the next frame start, level=7 and allowed=1. Popped order matches write order.
- Underflow: FIFO empty at a frame start -> underflow high for exactly one cycle, and DACDAT=0 for all 64 bits of that frame.
- Clear: level=5, assert clear with write_audio_out=1 -> level=0 next cycle, write dropped, in-progress frame bits unchanged.
- Mid-frame reset: drop resetn at bit_cnt=40 -> BCLK, LRCK and DACDAT are 0 immediately, level=0. After release, timing restarts from cycle 0.
